arbitro_escritura_br: RTL
=========================

// Module: arbitro_escritura_br
// PURPOSE
//  Shares the single write port of the 32x32 register bank between two writers:
//  A = ALU writeback, B = memory-load writeback. Each writer uses valid/ready.
//  Round-robin arbitration grants at most one write per cycle.
//  Registered outputs drive the bank's RegWrite/Write_Reg/Write_Data inputs.
//  A saturating stall counter exposes write-port contention for debug.
// PARAMETERS
//  DATA_W   32  width of write data
//  ADDR_W   5   width of register index
//  CNT_W    16  width of Stall_Count
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  ReqA_Valid   in   1       A presents a write
//  ReqA_Reg     in   ADDR_W  A destination register
//  ReqA_Data    in   DATA_W  A write data
//  ReqA_Ready   out  1       A beat accepted this cycle when Valid&Ready
//  ReqB_Valid   in   1       B presents a write
//  ReqB_Reg     in   ADDR_W  B destination register
//  ReqB_Data    in   DATA_W  B write data
//  ReqB_Ready   out  1       B beat accepted this cycle when Valid&Ready
//  RegWrite     out  1       to bank RegWrite
//  Write_Reg    out  ADDR_W  to bank Write_Reg
//  Write_Data   out  DATA_W  to bank Write_Data
//  Stall_Count  out  CNT_W   cycles in which some valid requester was not granted
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - RegWrite=0, Write_Reg=0, Write_Data=0, Stall_Count=0.
//    - last_grant=B, so A wins the first tie.
//  - Ready is combinational from Valid and last_grant only; never from Ready.
//    - Only A valid -> ReqA_Ready=1. Only B valid -> ReqB_Ready=1.
//    - Both valid -> grant the requester != last_grant; the other's Ready=0.
//    - Neither valid -> both Ready=0.
//  - Accept (Valid&Ready) updates last_grant to the winner. Idle leaves it unchanged.
//  - Latency is exactly 1 cycle. On the edge after acceptance:
//    - RegWrite=1.
//    - Write_Reg/Write_Data = the accepted beat's Reg/Data.
//  - No accept in a cycle -> RegWrite=0 next cycle; Write_Reg/Write_Data hold.
//  - Back-to-back: one write per cycle sustained. Both valid continuously -> A,B,A,B...
//  - Both requesters targeting the same register is not merged. Writes occur in grant order, one per cycle.
//  - Losing requester must hold Valid/Reg/Data stable until accepted.
//  - Stall_Count: +1 on each cycle where (ReqA_Valid&!ReqA_Ready)|(ReqB_Valid&!ReqB_Ready).
//    Saturates at 2^CNT_W-1; no wrap.
//  - Reset mid-operation: RegWrite drops to 0 immediately (async).
//    - A beat accepted in the cycle before reset is discarded; no write reaches the bank.
//    - Requesters re-issue after reset.
// CONFIGURATION
//  ZERO_REG_PROTECT_EN defined:
//    - A beat with Reg==0 is accepted normally (Ready, last_grant, Stall_Count unaffected).
//    - Next cycle RegWrite=0; Write_Reg/Write_Data hold. Keeps $zero at 0.
//  ZERO_REG_PROTECT_EN undefined: Reg==0 beats are written like any other.
// TESTING
//  - Reset: rst_n=0 with A,B valid -> RegWrite=0, Write_Reg=0, Write_Data=0,
//    Stall_Count=0, both Ready=0.
//  - Single: A valid Reg=5, Data=32'hDEADBEEF for 1 cycle -> ReqA_Ready=1.
//    Next cycle RegWrite=1, Write_Reg=5, Write_Data=DEADBEEF; RegWrite=0 after.
//  - Contention: A(Reg=3,Data=1) and B(Reg=3,Data=2) valid from reset.
//    -> grants A then B; writes 3<-1 then 3<-2. Stall_Count=1.
//  - Fairness: both valid 6 cycles with new beats each accept -> grant order A,B,A,B,A,B.
//    Stall_Count=6.
//  - Saturation (CNT_W=2): 5 contended cycles -> Stall_Count=3, holds at 3.
//  - Zero reg: A Reg=0, Data=7.
//    ZERO_REG_PROTECT_EN defined -> ReqA_Ready=1, RegWrite stays 0.
//    Undefined -> RegWrite=1, Write_Reg=0.
//  - Async reset: assert rst_n mid-cycle after an accept -> RegWrite=0 immediately.
//    No write follows deassertion.

Source files
------------

// File: rtl/arbitro_escritura_br.sv
// -----------------------------------------------------------------------------
// arbitro_escritura_br
//
// Shares the single write port of the 32x32 register bank between two writers:
//   A = ALU writeback, B = memory-load writeback.
// Each writer offers beats with a valid/ready handshake. Round-robin
// arbitration accepts at most one beat per cycle. The accepted beat appears on
// the registered bank-side outputs exactly one cycle later. A saturating
// counter records cycles in which some valid requester was held off.
//
// Parameters
//   DATA_W  width of write data          (default 32)
//   ADDR_W  width of register index      (default 5)
//   CNT_W   width of Stall_Count         (default 16)
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous, active-low reset
//   ReqA_Valid   in   A presents a write
//   ReqA_Reg     in   A destination register
//   ReqA_Data    in   A write data
//   ReqA_Ready   out  A beat accepted this cycle when Valid&Ready
//   ReqB_Valid   in   B presents a write
//   ReqB_Reg     in   B destination register
//   ReqB_Data    in   B write data
//   ReqB_Ready   out  B beat accepted this cycle when Valid&Ready
//   RegWrite     out  bank write enable (registered)
//   Write_Reg    out  bank write index  (registered)
//   Write_Data   out  bank write data   (registered)
//   Stall_Count  out  saturating count of contended cycles
//
// Build option
//   ZERO_REG_PROTECT_EN  when defined, beats addressed to register 0 are
//                        accepted normally but never reach the bank.
//
// Arbitration state (last_grant)
//   state   | meaning
//   GRANT_A | A won the most recent accept; B wins the next tie
//   GRANT_B | B won the most recent accept (reset value); A wins the next tie
// -----------------------------------------------------------------------------
module arbitro_escritura_br #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqA_Valid,
  input  logic [ADDR_W-1:0] ReqA_Reg,
  input  logic [DATA_W-1:0] ReqA_Data,
  output logic              ReqA_Ready,
  input  logic              ReqB_Valid,
  input  logic [ADDR_W-1:0] ReqB_Reg,
  input  logic [DATA_W-1:0] ReqB_Data,
  output logic              ReqB_Ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_Reg,
  output logic [DATA_W-1:0] Write_Data,
  output logic [CNT_W-1:0]  Stall_Count
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  grant_t              last_grant;
  grant_t              last_grant_next;
  logic                grant_a;
  logic                grant_b;
  logic                accept;
  logic                stall;
  logic                write_en;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;

  // ---------------------------------------------------------------------------
  // Arbitration state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_B;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant decision and next arbitration state.
  // Grants depend only on the two Valids and last_grant, so neither requester
  // can create a loop through its own Ready. Grants are held off while reset is
  // asserted so nothing looks accepted during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_a         = 1'b0;
    grant_b         = 1'b0;
    last_grant_next = last_grant;

    if (rst_n) begin
      if (ReqA_Valid && ReqB_Valid) begin
        if (last_grant == GRANT_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else if (ReqA_Valid) begin
        grant_a = 1'b1;
      end else if (ReqB_Valid) begin
        grant_b = 1'b1;
      end
    end

    if (grant_a) begin
      last_grant_next = GRANT_A;
    end else if (grant_b) begin
      last_grant_next = GRANT_B;
    end
  end

  assign ReqA_Ready = grant_a;
  assign ReqB_Ready = grant_b;

  // ---------------------------------------------------------------------------
  // Winning beat selection
  // ---------------------------------------------------------------------------
  assign accept   = grant_a | grant_b;
  assign sel_reg  = grant_b ? ReqB_Reg  : ReqA_Reg;
  assign sel_data = grant_b ? ReqB_Data : ReqA_Data;

`ifdef ZERO_REG_PROTECT_EN
  // Register 0 is hardwired to zero in the bank; swallow such beats after the
  // handshake so the requester still sees a normal accept.
  assign write_en = accept && (sel_reg != '0);
`else
  assign write_en = accept;
`endif

  // A requester is stalled when it is valid but not granted this cycle.
  assign stall = (ReqA_Valid && !grant_a) || (ReqB_Valid && !grant_b);

  // ---------------------------------------------------------------------------
  // Registered bank-side outputs. Index/data hold when no write occurs so the
  // bank inputs only toggle on real writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      Write_Reg  <= '0;
      Write_Data <= '0;
    end else begin
      RegWrite <= write_en;
      if (write_en) begin
        Write_Reg  <= sel_reg;
        Write_Data <= sel_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Contention counter, saturating at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_Count <= '0;
    end else if (stall && (Stall_Count != CNT_MAX)) begin
      Stall_Count <= Stall_Count + CNT_ONE;
    end
  end

endmodule
